// File: rtl/famicom_pad_responder_if.sv
// Purpose : groups the controller-port signals between the joystick/shell side and the pad responder.
// Latency : none, plain wiring bundle.
// Backpressure: none; strobes are free-running from the shell, the pad always answers.
// Ports (signals):
//   joy_buttons   8   host buttons, active-high pressed ([0]A [1]B [2]Sel [3]Start [4]Up [5]Down [6]Left [7]Right)
//   famicom_latch 1   latch strobe from the shell, async
//   famicom_pulse 1   shift clock from the shell, async, shift on rising edge
//   famicom_data  1   serial data back to the shell, active-low
//   poll_active   1   latches arriving within the idle timeout
//   bit_index     4   shifts since last load, saturating at 8
//   poll_count    16  completed polls, wrapping
interface famicom_pad_responder_if;
  logic [7:0]  joy_buttons;
  logic        famicom_latch;
  logic        famicom_pulse;
  logic        famicom_data;
  logic        poll_active;
  logic [3:0]  bit_index;
  logic [15:0] poll_count;

  // master: the shell/joystick side driving strobes and buttons
  modport master (
    output joy_buttons, famicom_latch, famicom_pulse,
    input  famicom_data, poll_active, bit_index, poll_count
  );

  // slave: the pad responder
  modport slave (
    input  joy_buttons, famicom_latch, famicom_pulse,
    output famicom_data, poll_active, bit_index, poll_count
  );
endinterface

// File: rtl/famicom_pad_responder.sv
// Purpose : CD4021-style Famicom/NES pad emulation answering async latch/pulse strobes with button bits.
// Latency : famicom_data moves SYNC_STAGES+2 clk_sys cycles after the strobe edge that caused it.
// Backpressure: none; every synchronised strobe edge is acted on, latch dominates pulse.
// Ports:
//   clk_sys  system clock, all logic on rising edge
//   reset_n  async active-low reset, released synchronously inside
//   pad      slave modport of famicom_pad_responder_if (buttons, strobes, data and status)
module famicom_pad_responder #(
  parameter int SYNC_STAGES  = 2,        // min 2
  parameter int IDLE_TIMEOUT = 1000000,
  parameter int TIMEOUT_W    = 20        // must hold IDLE_TIMEOUT
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  famicom_pad_responder_if.slave  pad
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(IDLE_TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE     = TIMEOUT_W'(1);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clk_sys edge so that no flop
  // sees the release close to its clock.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] pulse_sync_q, pulse_sync_d;
  logic                   latch_prev_q, latch_prev_d;
  logic                   pulse_prev_q, pulse_prev_d;
  state_t                 state_q, state_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   data_q, data_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [15:0]            poll_cnt_q, poll_cnt_d;
  logic [TIMEOUT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                   poll_active_q, poll_active_d;

  logic latch_s, pulse_s;
  logic latch_rise, pulse_rise;
  logic timeout_hit;

  assign latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad.famicom_latch};
  assign pulse_sync_d = {pulse_sync_q[SYNC_STAGES-2:0], pad.famicom_pulse};
  assign latch_s      = latch_sync_q[SYNC_STAGES-1];
  assign pulse_s      = pulse_sync_q[SYNC_STAGES-1];
  assign latch_prev_d = latch_s;
  assign pulse_prev_d = pulse_s;
  assign latch_rise   = latch_s & ~latch_prev_q;
  assign pulse_rise   = pulse_s & ~pulse_prev_q;

  // Fires for exactly one cycle: the cycle in which the idle counter steps
  // onto IDLE_TIMEOUT. After that the counter sits saturated and quiet.
  assign timeout_hit  = !latch_rise && (idle_cnt_q == TIMEOUT_MAX - CNT_ONE);

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_idx_d     = bit_idx_q;
    poll_cnt_d    = poll_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    poll_active_d = poll_active_q;

    // Idle watchdog
    if (latch_rise) begin
      idle_cnt_d    = '0;
      poll_active_d = 1'b1;
    end else if (idle_cnt_q != TIMEOUT_MAX) begin
      idle_cnt_d = idle_cnt_q + CNT_ONE;
    end
    if (timeout_hit) begin
      poll_active_d = 1'b0;
    end

    // Latch level dominates everything: transparent load, index cleared,
    // any pulse edge in the same cycle is dropped.
    if (latch_s) begin
      state_d   = ST_LOAD;
      shreg_d   = ~pad.joy_buttons;
      bit_idx_d = 4'd0;
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (pulse_rise) begin
            shreg_d   = {1'b1, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd7) begin
              state_d    = ST_DONE;
              poll_cnt_d = poll_cnt_q + 16'd1;
            end
          end
        end
        default: begin
          // IDLE and DONE ignore pulses and hold the register
        end
      endcase
    end

    data_d = shreg_q[0];
  end

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      latch_sync_q  <= '0;
      pulse_sync_q  <= '0;
      latch_prev_q  <= 1'b0;
      pulse_prev_q  <= 1'b0;
      state_q       <= ST_IDLE;
      shreg_q       <= 8'hFF;
      data_q        <= 1'b1;
      bit_idx_q     <= 4'd0;
      poll_cnt_q    <= 16'd0;
      idle_cnt_q    <= '0;
      poll_active_q <= 1'b0;
    end else begin
      latch_sync_q  <= latch_sync_d;
      pulse_sync_q  <= pulse_sync_d;
      latch_prev_q  <= latch_prev_d;
      pulse_prev_q  <= pulse_prev_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      bit_idx_q     <= bit_idx_d;
      poll_cnt_q    <= poll_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      poll_active_q <= poll_active_d;
    end
  end

  assign pad.famicom_data = data_q;
  assign pad.poll_active  = poll_active_q;
  assign pad.bit_index    = bit_idx_q;
  assign pad.poll_count   = poll_cnt_q;

endmodule
